// File: rtl/mdu_seq.sv
// mdu_seq: iterative HI/LO multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Rev 1.0 -- initial release.
`default_nettype none

module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // product high half / partial remainder
    logic [WIDTH-1:0] sh_q, sh_d;       // multiplier -> product low half / dividend -> quotient
    logic [WIDTH-1:0] opd_q, opd_d;     // multiplicand magnitude / divisor magnitude
    logic [WIDTH-1:0] araw_q, araw_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             busy_q, done_q, done_d;

    logic             w_signed;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [WIDTH:0]   w_mul_sum;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_diff;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix, w_rem_fix;

    assign w_signed = ~op[0];
    assign w_a_mag  = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_b_mag  = (w_signed && b[WIDTH-1]) ? -b : b;

    assign w_mul_sum  = {1'b0, acc_q} + {1'b0, (sh_q[0] ? opd_q : '0)};
    // Restoring step: the shifted remainder never exceeds 2*divisor, so the
    // modular W-bit difference is exact whenever the trial subtraction succeeds.
    assign w_div_ge   = ({acc_q, sh_q[WIDTH-1]} >= {1'b0, opd_q});
    assign w_div_diff = {acc_q[WIDTH-2:0], sh_q[WIDTH-1]} - opd_q;

    assign w_prod     = {acc_q, sh_q};
    assign w_prod_fix = neg_res_q ? -w_prod : w_prod;
    assign w_quo_fix  = neg_res_q ? -sh_q : sh_q;
    assign w_rem_fix  = neg_rem_q ? -acc_q : acc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        opd_d     = opd_q;
        araw_d    = araw_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    if (!op[2]) begin
                        state_d   = S_RUN;
                        cnt_d     = CNT_INIT;
                        is_div_d  = op[1];
                        acc_d     = '0;
                        sh_d      = op[1] ? w_a_mag : w_b_mag;
                        opd_d     = op[1] ? w_b_mag : w_a_mag;
                        araw_d    = a;
                        neg_res_d = w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_d = w_signed && a[WIDTH-1];
                        dz_d      = op[1] && (b == '0);
                    end else if (!op[1]) begin
                        if (op[0]) lo_d = a;
                        else       hi_d = a;
                    end
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_d = w_div_ge ? w_div_diff : {acc_q[WIDTH-2:0], sh_q[WIDTH-1]};
                        sh_d  = {sh_q[WIDTH-2:0], w_div_ge};
                    end else begin
                        acc_d = w_mul_sum[WIDTH:1];
                        sh_d  = {w_mul_sum[0], sh_q[WIDTH-1:1]};
                    end
                    if (cnt_q == '0) state_d = S_FIX;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = w_prod_fix[WIDTH-1:0];
                    end else if (dz_q) begin
                        hi_d = araw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = w_rem_fix;
                        lo_d = w_quo_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            sh_q      <= '0;
            opd_q     <= '0;
            araw_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            sh_q      <= sh_d;
            opd_q     <= opd_d;
            araw_q    <= araw_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: scoreboard bench for mdu_seq; expected HI/LO come from a 64-bit arithmetic model.
// Rev 1.0 -- initial release.
`default_nettype none

module tb_mdu_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        cancel;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi, m_lo;

    mdu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // {hi, lo} that the architecture defines for each mul/div op
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            3'd0: return sx * sy;
            3'd1: return ux * uy;
            3'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest outstanding op.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("hilo_result", {hi, lo}, e);
            end
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] e;
        int cyc;
        e = model(o, x, y);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(cyc), 64'd33);
        m_hi = e[63:32];
        m_lo = e[31:0];
    endtask

    task automatic run_abort(input bit use_rst);
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'hFFFF_FFF9; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy_in_run", 64'(busy), 64'd1);
        if (use_rst) rst = 1'b1;
        else         cancel = 1'b1;
        @(negedge clk);
        rst = 1'b0; cancel = 1'b0;
        if (use_rst) begin
            m_hi = 32'd0;
            m_lo = 32'd0;
        end
        chk(use_rst ? "rst_busy" : "cancel_busy", 64'(busy), 64'd0);
        chk(use_rst ? "rst_hilo" : "cancel_hilo", {hi, lo}, {m_hi, m_lo});
        chk(use_rst ? "rst_done" : "cancel_done", 64'(done), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; cancel = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);

        // Directed arithmetic corners
        run_op(3'd0, 32'hFFFF_FFF9, 32'd3);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd3, 32'd100, 32'd0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FF9C, 32'd0);

        // MTHI then MTLO back to back
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'h1234;
        @(negedge clk);
        chk("mt_busy0", 64'(busy), 64'd0);
        op = 3'd5; a = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        chk("mt_busy1", 64'(busy), 64'd0);
        m_hi = 32'h1234; m_lo = 32'h5678;
        chk("mt_hilo", {hi, lo}, {m_hi, m_lo});

        // cancel together with start in IDLE, and a reserved op: nothing happens
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF; cancel = 1'b1;
        @(negedge clk);
        op = 3'd0;
        @(negedge clk);
        cancel = 1'b0; op = 3'd6;
        @(negedge clk);
        op = 3'd7;
        @(negedge clk);
        start = 1'b0;
        chk("idle_noop_busy", 64'(busy), 64'd0);
        chk("idle_noop_hilo", {hi, lo}, {m_hi, m_lo});

        // abort mid-RUN, then a fresh op right after
        run_abort(1'b0);
        run_op(3'd1, 32'd12345, 32'd678);
        run_abort(1'b1);
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000);

        // randomized ops with a bias toward edge operands
        for (int i = 0; i < 24; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: x = 32'h8000_0000;
                3: y = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(3'($urandom_range(0, 3)), x, y);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        chk("final_hilo", {hi, lo}, {m_hi, m_lo});
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
